multimode_ff_reg: RTL and testbench

- Parametrised WIDTH-bit register bank; each bit is a flip-flop whose behaviour is selected at run time by MODE: JK, T, D, or synchronous up/down counter.
- Replaces discrete single-bit JK/T flip-flop instances in datapaths, toggle banks and small counters.
- Also provides registered terminal-count and change-detect flags for downstream control logic.

---
 rtl/multimode_ff_reg.sv | 85 ++++++++
 tb/tb_multimode_ff_reg.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/multimode_ff_reg.sv
// Run-time selectable JK / T / D / up-down counter register bank with registered
// complement, terminal-count pulse and change-detect flag.
module multimode_ff_reg #(
    parameter int unsigned     WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             DIR,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_NOT,
    output logic             TC,
    output logic             CHANGED
);

    typedef enum logic [1:0] {
        ModeJk    = 2'b00,
        ModeT     = 2'b01,
        ModeD     = 2'b10,
        ModeCount = 2'b11
    } mode_e;

    localparam logic [WIDTH:0] CountOne = {{WIDTH{1'b0}}, 1'b1};

    mode_e            mode;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_not_q;
    logic             tc_q, changed_q;
    logic             wrap;
    logic [WIDTH:0]   count_up, count_dn;

    assign mode = mode_e'(MODE);

    // Extra top bit is the carry (up) or borrow (down), i.e. the wrap indication.
    assign count_up = {1'b0, q_q} + CountOne;
    assign count_dn = {1'b0, q_q} - CountOne;

    always_comb begin
        q_d  = q_q;
        wrap = 1'b0;
        unique case (mode)
            ModeJk:    q_d = (J & ~q_q) | (~K & q_q);
            ModeT:     q_d = q_q ^ J;
            ModeD:     q_d = J;
            ModeCount: begin
                if (DIR) begin
                    q_d  = count_up[WIDTH-1:0];
                    wrap = count_up[WIDTH];
                end else begin
                    q_d  = count_dn[WIDTH-1:0];
                    wrap = count_dn[WIDTH];
                end
            end
            default: q_d = q_q;
        endcase
    end

    // The complement is held in its own register so Q_NOT is never combinational.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q       <= RESET_VAL;
            q_not_q   <= ~RESET_VAL;
            tc_q      <= 1'b0;
            changed_q <= 1'b0;
        end else if (EN) begin
            q_q       <= q_d;
            q_not_q   <= ~q_d;
            tc_q      <= wrap;
            changed_q <= (q_d != q_q);
        end else begin
            tc_q      <= 1'b0;
            changed_q <= 1'b0;
        end
    end

    assign Q       = q_q;
    assign Q_NOT   = q_not_q;
    assign TC      = tc_q;
    assign CHANGED = changed_q;

endmodule

// File: tb/tb_multimode_ff_reg.sv
// Directed-vector bench: WIDTH=4 instance driven from a table, plus a WIDTH=1
// instance exercised in COUNT mode by hand.
module tb_multimode_ff_reg;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       rst, en, dir;
    logic [1:0] mode;
    logic [3:0] j, k, q, q_not;
    logic       tc, changed;

    multimode_ff_reg #(.WIDTH(4), .RESET_VAL(4'b0101)) dut4 (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .DIR(dir),
        .J(j), .K(k), .Q(q), .Q_NOT(q_not), .TC(tc), .CHANGED(changed)
    );

    // WIDTH=1 instance
    logic       rst1, en1, dir1;
    logic [1:0] mode1;
    logic [0:0] j1, k1, q1, q_not1;
    logic       tc1, changed1;

    multimode_ff_reg #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .CLK(clk), .RST(rst1), .EN(en1), .MODE(mode1), .DIR(dir1),
        .J(j1), .K(k1), .Q(q1), .Q_NOT(q_not1), .TC(tc1), .CHANGED(changed1)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       dir;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] exp_q;
        logic       exp_tc;
        logic       exp_ch;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic e, input logic [1:0] m, input logic d,
                       input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] eq,
                       input logic et, input logic ec);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.dir = d; v.j = jj; v.k = kk;
        v.exp_q = eq; v.exp_tc = et; v.exp_ch = ec;
        vecs.push_back(v);
    endtask

    task automatic check4(input string name, input logic [3:0] eq, input logic et,
                          input logic ec);
        total++;
        if (q !== eq || q_not !== ~eq || tc !== et || changed !== ec) begin
            bad++;
            $display("FAIL %s: got q=%b q_not=%b tc=%b ch=%b, want q=%b q_not=%b tc=%b ch=%b",
                     name, q, q_not, tc, changed, eq, ~eq, et, ec);
        end
    endtask

    task automatic check1(input string name, input logic eq, input logic et, input logic ec);
        total++;
        if (q1 !== eq || q_not1 !== ~eq || tc1 !== et || changed1 !== ec) begin
            bad++;
            $display("FAIL %s: got q=%b q_not=%b tc=%b ch=%b, want q=%b q_not=%b tc=%b ch=%b",
                     name, q1, q_not1, tc1, changed1, eq, ~eq, et, ec);
        end
    endtask

    initial begin
        // rst en mode dir j k | q tc ch
        add(1, 0, 2'b00, 0, 4'b0000, 4'b0000, 4'b0101, 0, 0); // reset
        add(0, 0, 2'b00, 0, 4'b1111, 4'b1111, 4'b0101, 0, 0); // hold x3
        add(0, 0, 2'b11, 1, 4'b1111, 4'b1111, 4'b0101, 0, 0);
        add(0, 0, 2'b10, 0, 4'b0000, 4'b1111, 4'b0101, 0, 0);
        add(0, 1, 2'b10, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1); // D clear
        add(0, 1, 2'b00, 0, 4'b1100, 4'b0011, 4'b1100, 0, 1); // JK set/reset
        add(0, 1, 2'b00, 0, 4'b1111, 4'b1111, 4'b0011, 0, 1); // JK toggle
        add(0, 1, 2'b00, 0, 4'b0000, 4'b0000, 4'b0011, 0, 0); // JK hold
        add(0, 1, 2'b01, 0, 4'b1010, 4'b0000, 4'b1001, 0, 1); // T
        add(0, 1, 2'b01, 0, 4'b1010, 4'b0000, 4'b0011, 0, 1);
        add(0, 1, 2'b10, 0, 4'b0110, 4'b1111, 4'b0110, 0, 1); // D
        add(0, 1, 2'b10, 0, 4'b1110, 4'b0000, 4'b1110, 0, 1);
        add(0, 1, 2'b11, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1); // count up
        add(0, 1, 2'b11, 1, 4'b0000, 4'b0000, 4'b0000, 1, 1); // wrap
        add(0, 1, 2'b11, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1);
        add(0, 1, 2'b10, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        add(0, 1, 2'b11, 0, 4'b1010, 4'b0101, 4'b1111, 1, 1); // wrap down
        add(0, 1, 2'b00, 0, 4'b1111, 4'b0000, 4'b1111, 0, 0); // JK to all-ones: no TC
        add(0, 1, 2'b10, 0, 4'b0111, 4'b0000, 4'b0111, 0, 1);
        add(0, 1, 2'b11, 1, 4'b0000, 4'b0000, 4'b1000, 0, 1); // EN toggling
        add(0, 0, 2'b11, 1, 4'b0000, 4'b0000, 4'b1000, 0, 0);
        add(0, 1, 2'b11, 1, 4'b0000, 4'b0000, 4'b1001, 0, 1);
        add(0, 1, 2'b10, 0, 4'b1111, 4'b0000, 4'b1111, 0, 1);
        add(1, 1, 2'b11, 1, 4'b0000, 4'b0000, 4'b0101, 0, 0); // reset beats count wrap
        add(0, 1, 2'b01, 0, 4'b0000, 4'b1111, 4'b0101, 0, 0); // T all-zero
        add(0, 1, 2'b01, 0, 4'b0101, 4'b0000, 4'b0000, 0, 1); // T to zero: no TC
        add(0, 1, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        rst = 1'b1; en = 1'b0; mode = 2'b00; dir = 1'b0; j = '0; k = '0;
        rst1 = 1'b1; en1 = 1'b0; mode1 = 2'b00; dir1 = 1'b0; j1 = '0; k1 = '0;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode; dir = vecs[i].dir;
            j = vecs[i].j; k = vecs[i].k;
            @(posedge clk);
            #1;
            check4($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_tc, vecs[i].exp_ch);
        end

        // WIDTH=1 counter: up from 0 gives 1,0,1,0 with TC on each 1->0 wrap.
        @(negedge clk);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        check1("w1_reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst1 = 1'b0; en1 = 1'b1; mode1 = 2'b11; dir1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            check1($sformatf("w1_up%0d", n), (n % 2 == 0), (n % 2 == 1), 1'b1);
        end
        // Down from 0 wraps to 1 with TC.
        @(negedge clk);
        dir1 = 1'b0;
        @(posedge clk);
        #1;
        check1("w1_down_wrap", 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        en1 = 1'b0;
        @(posedge clk);
        #1;
        check1("w1_hold", 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
